// File: rtl/generatore_di_sequenza.sv
// Moore generator of the symbol sequence 11,01,10 repeated n_rip times,
// with GAP idle symbols between repetitions and a one-cycle done pulse at the end.
module generatore_di_sequenza #(
    parameter int unsigned GAP      = 1,
    parameter logic [1:0]  IDLE_SYM = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] n_rip,
    output logic [1:0] x1_x0,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StT11,
        StT01,
        StT10,
        StGapw,
        StDone
    } state_e;

    localparam logic [3:0] GapLoad = 4'(GAP);

    state_e     state_q, state_d;
    logic [3:0] rep_cnt_q, rep_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rep_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                // abort wins over start; a zero count is simply not accepted
                if (start && !abort && (n_rip != 4'd0)) begin
                    rep_cnt_d = n_rip;
                    state_d   = StT11;
                end
            end
            StT11: state_d = abort ? StIdle : StT01;
            StT01: state_d = abort ? StIdle : StT10;
            StT10: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    rep_cnt_d = rep_cnt_q - 4'd1;
                    if (rep_cnt_q <= 4'd1) begin
                        state_d = StDone;
                    end else if (GapLoad == 4'd0) begin
                        state_d = StT11;
                    end else begin
                        gap_cnt_d = GapLoad;
                        state_d   = StGapw;
                    end
                end
            end
            StGapw: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                    if (gap_cnt_q <= 4'd1) begin
                        state_d = StT11;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x1_x0 = IDLE_SYM;
        valid = 1'b0;
        done  = 1'b0;
        busy  = (state_q != StIdle);
        unique case (state_q)
            StT11: begin
                x1_x0 = 2'b11;
                valid = 1'b1;
            end
            StT01: begin
                x1_x0 = 2'b01;
                valid = 1'b1;
            end
            StT10: begin
                x1_x0 = 2'b10;
                valid = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_generatore_di_sequenza.sv
// Scoreboard bench: three instances with different GAP/IDLE_SYM; the stimulus queues the
// expected per-cycle output of every busy cycle, a monitor pops and compares at negedge.
module tb_generatore_di_sequenza;

    localparam int N = 3;

    typedef struct packed {
        logic [1:0] sym;
        logic       vld;
        logic       dn;
    } entry_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           abort = 1'b0;
    logic [3:0]     n_rip = 4'd0;
    logic [N-1:0]   start = '0;
    logic [1:0]     sym [N];
    logic [N-1:0]   valid, busy, done;

    entry_t exp_q [N][$];
    int     n_vec = 0;
    int     n_err = 0;
    int     hits  = 0;
    logic [5:0] hist = 6'd0;

    always #5 clock = ~clock;

    for (genvar i = 0; i < N; i++) begin : g_dut
        generatore_di_sequenza #(
            .GAP     (i == 0 ? 1 : (i == 1 ? 2 : 0)),
            .IDLE_SYM(i == 2 ? 2'b01 : 2'b00)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .start(start[i]),
            .abort(abort),
            .n_rip(n_rip),
            .x1_x0(sym[i]),
            .valid(valid[i]),
            .busy (busy[i]),
            .done (done[i])
        );
    end

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
    endfunction

    function automatic logic [1:0] idle_of(input int k);
        return (k == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [1:0] s, input logic v, input logic d);
        entry_t e;
        e.sym = s;
        e.vld = v;
        e.dn  = d;
        exp_q[k].push_back(e);
    endtask

    task automatic push_seq(input int k, input int n);
        for (int r = 1; r <= n; r++) begin
            push(k, 2'b11, 1'b1, 1'b0);
            push(k, 2'b01, 1'b1, 1'b0);
            push(k, 2'b10, 1'b1, 1'b0);
            if (r < n) begin
                for (int g = 0; g < gap_of(k); g++) push(k, idle_of(k), 1'b0, 1'b0);
            end
        end
        push(k, idle_of(k), 1'b0, 1'b1);
    endtask

    // Returns one time unit after the accepting edge.
    task automatic launch(input int k, input logic [3:0] n, input bit run);
        @(negedge clock);
        #1;
        start[k] = 1'b1;
        n_rip    = n;
        if (run) push_seq(k, int'(n));
        @(posedge clock);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            #2;
            t++;
        end while ((busy[k] || exp_q[k].size() != 0) && t < 80);
        chk("settle_busy", k, busy[k], 0);
        chk("queue_drained", k, exp_q[k].size(), 0);
    endtask

    always @(negedge clock) begin
        entry_t e;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                if (busy[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("busy_without_expected", k, busy[k], 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk("sym", k, sym[k], e.sym);
                        chk("valid", k, valid[k], e.vld);
                        chk("done", k, done[k], e.dn);
                    end
                end else begin
                    chk("idle_sym", k, sym[k], idle_of(k));
                    chk("idle_valid", k, valid[k], 0);
                    chk("idle_done", k, done[k], 0);
                end
            end
            // Reference recognizer for 11,01,10 on the GAP=0 stream
            hist = {hist[3:0], sym[2]};
            if (hist == 6'b110110) hits++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled between edges
        #3;
        for (int k = 0; k < N; k++) begin
            chk("rst_sym", k, sym[k], idle_of(k));
            chk("rst_valid", k, valid[k], 0);
            chk("rst_busy", k, busy[k], 0);
            chk("rst_done", k, done[k], 0);
        end
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;

        // n_rip=1, GAP=1
        launch(0, 4'd1, 1'b1);
        wait_idle(0);

        // n_rip=3, GAP=2: 14 busy cycles
        launch(1, 4'd3, 1'b1);
        wait_idle(1);

        // n_rip=2, GAP=0: back-to-back, two recognizer hits
        hits = 0;
        launch(2, 4'd2, 1'b1);
        wait_idle(2);
        chk("recognizer_hits", 2, hits, 2);

        // start re-asserted with a new count while busy is ignored
        launch(0, 4'd2, 1'b1);
        @(posedge clock);
        #1;
        start[0] = 1'b1;
        n_rip    = 4'd5;
        @(posedge clock);
        #1 start[0] = 1'b0;
        wait_idle(0);

        // abort in T01
        @(negedge clock);
        #1;
        start[0] = 1'b1;
        n_rip    = 4'd3;
        push(0, 2'b11, 1'b1, 1'b0);
        push(0, 2'b01, 1'b1, 1'b0);
        @(posedge clock);
        #1 start[0] = 1'b0;
        @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        chk("abort_busy", 0, busy[0], 0);
        chk("abort_sym", 0, sym[0], idle_of(0));
        wait_idle(0);

        // start together with abort in IDLE
        @(negedge clock);
        #1;
        start[0] = 1'b1;
        abort    = 1'b1;
        n_rip    = 4'd4;
        @(posedge clock);
        #1;
        start[0] = 1'b0;
        abort    = 1'b0;
        chk("start_abort_busy", 0, busy[0], 0);
        repeat (3) @(negedge clock);

        // n_rip=0 is not accepted
        launch(0, 4'd0, 1'b0);
        chk("zero_rip_busy", 0, busy[0], 0);
        repeat (3) @(negedge clock);

        // asynchronous reset between edges during T10
        launch(1, 4'd2, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("pre_reset_sym", 1, sym[1], 2'b10);
        chk("pre_reset_valid", 1, valid[1], 1);
        reset = 1'b1;
        #1;
        chk("async_rst_sym", 1, sym[1], idle_of(1));
        chk("async_rst_valid", 1, valid[1], 0);
        chk("async_rst_busy", 1, busy[1], 0);
        chk("async_rst_done", 1, done[1], 0);
        exp_q[1].delete();
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (6) @(negedge clock);
        #2;
        chk("post_reset_busy", 1, busy[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
